// File: rtl/spi_fsm.sv
// rtl/spi_fsm.sv - SPI slave transaction sequencer: address phase, then read or write data phase
module spi_fsm #(
  parameter int BITCOUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_cond,
  input  logic       sclk_posedge,
  input  logic       sclk_negedge,
  input  logic       rw_bit,
  output logic       sample_en,
  output logic       addr_we,
  output logic       sr_we,
  output logic       miso_bufe,
  output logic       dm_we,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_GET   = 3'd5,
    WRITE_STORE = 3'd6,
    DONE        = 3'd7
  } state_t;

  // Count value at which the next counted edge closes the phase
  localparam logic [3:0] LAST = 4'(BITCOUNT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // State and edge counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: each phase counts only its own SCLK edge; chip-select release wins over everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!cs_cond) state_d = GET_ADDR;
      end
      GET_ADDR: begin
        if (sclk_posedge) begin
          if (cnt_q == LAST) state_d = GOT_ADDR;
          else               cnt_d   = cnt_q + 4'd1;
        end
      end
      GOT_ADDR: begin
        state_d = rw_bit ? READ_LOAD : WRITE_GET;
      end
      READ_LOAD: begin
        state_d = READ_SHIFT;
      end
      READ_SHIFT: begin
        if (sclk_negedge) begin
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + 4'd1;
        end
      end
      WRITE_GET: begin
        if (sclk_posedge) begin
          if (cnt_q == LAST) state_d = WRITE_STORE;
          else               cnt_d   = cnt_q + 4'd1;
        end
      end
      WRITE_STORE: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (cs_cond) state_d = IDLE;
    // Every phase starts counting from zero
    if (state_d != state_q) cnt_d = 4'd0;
  end

  // Moore strobes from the registered state; sample_en passes the posedge through with no delay
  always_comb begin
    addr_we   = (state_q == GOT_ADDR);
    sr_we     = (state_q == READ_LOAD);
    miso_bufe = (state_q == READ_SHIFT);
    dm_we     = (state_q == WRITE_STORE);
    sample_en = sclk_posedge && ((state_q == GET_ADDR) || (state_q == WRITE_GET));
    state     = state_q;
  end

endmodule

// File: tb/tb_spi_fsm.sv
// tb/tb_spi_fsm.sv - table-driven self-checking bench for spi_fsm
module tb_spi_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_cond;
  logic       sclk_posedge;
  logic       sclk_negedge;
  logic       rw_bit;
  logic       sample_en;
  logic       addr_we;
  logic       sr_we;
  logic       miso_bufe;
  logic       dm_we;
  logic [2:0] state;

  spi_fsm #(.BITCOUNT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cs_cond      (cs_cond),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .rw_bit       (rw_bit),
    .sample_en    (sample_en),
    .addr_we      (addr_we),
    .sr_we        (sr_we),
    .miso_bufe    (miso_bufe),
    .dm_we        (dm_we),
    .state        (state)
  );

  always #5 clk = ~clk;

  // One clk cycle of stimulus: inputs, sample_en expected during the cycle, state after the edge
  typedef struct {
    logic cs;
    logic pos;
    logic neg;
    logic rw;
    int   se;
    int   nxt;
  } vec_t;

  vec_t vecs[$];
  int   exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cur   = 0;

  // Strobes {addr_we, sr_we, miso_bufe, dm_we} expected in a given state
  function automatic int strobes(input int s);
    case (s)
      2:       return 4'b1000;
      3:       return 4'b0100;
      4:       return 4'b0010;
      6:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic cs, input logic pos, input logic neg, input logic rw,
                     input int se, input int nxt);
    vec_t v;
    v.cs = cs; v.pos = pos; v.neg = neg; v.rw = rw; v.se = se; v.nxt = nxt;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    int got_outs;
    int e;
    @(negedge clk);
    cs_cond = v.cs; sclk_posedge = v.pos; sclk_negedge = v.neg; rw_bit = v.rw;
    exp_q.push_back(v.nxt);
    #1;
    check($sformatf("vec%0d sample_en", idx), int'(sample_en), v.se);
    got_outs = {28'd0, addr_we, sr_we, miso_bufe, dm_we};
    check($sformatf("vec%0d strobes_in_cycle", idx), got_outs, strobes(cur));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("vec%0d state", idx), int'(state), e);
    got_outs = {28'd0, addr_we, sr_we, miso_bufe, dm_we};
    check($sformatf("vec%0d strobes_after", idx), got_outs, strobes(e));
    cur = e;
  endtask

  task automatic addr_phase(input logic rw);
    add(0, 0, 0, rw, 0, 1);
    for (int i = 0; i < 7; i++) add(0, 1, 0, rw, 1, 1);
    add(0, 1, 0, rw, 1, 2);
  endtask

  initial begin
    vec_t v;
    int   got_outs;

    // Write transaction, with ignored and simultaneous edges sprinkled in
    addr_phase(1'b0);
    add(0, 1, 0, 0, 0, 5);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 1, 5);
    add(0, 0, 1, 0, 0, 5);
    add(0, 1, 1, 0, 1, 5);
    add(0, 1, 0, 0, 1, 6);
    add(0, 1, 1, 0, 0, 7);
    add(0, 1, 1, 0, 0, 7);
    add(1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    // Read transaction, five negedges ignored during the address phase
    add(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 1, 1, 1);
    add(0, 1, 0, 1, 1, 2);
    add(0, 0, 0, 1, 0, 3);
    add(0, 0, 1, 1, 0, 4);
    add(0, 1, 0, 1, 0, 4);
    for (int i = 0; i < 7; i++) add(0, 0, 1, 1, 0, 4);
    add(0, 1, 1, 1, 0, 7);
    add(0, 0, 0, 1, 0, 7);
    add(1, 0, 0, 0, 0, 0);
    // Abort after 3 address posedges, then a fresh 8-posedge address phase
    add(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0);
    addr_phase(1'b0);
    add(1, 0, 0, 0, 0, 0);
    // Chip select released during WRITE_STORE
    addr_phase(1'b0);
    add(0, 0, 0, 0, 0, 5);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 1, 5);
    add(0, 1, 0, 0, 1, 6);
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);

    // Reset state
    reset = 1'b1; cs_cond = 1'b1; sclk_posedge = 1'b0; sclk_negedge = 1'b0; rw_bit = 1'b0;
    #2;
    check("reset state", int'(state), 0);
    got_outs = {27'd0, sample_en, addr_we, sr_we, miso_bufe, dm_we};
    check("reset outputs", got_outs, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset in the middle of WRITE_GET
    for (int i = 0; i < 9; i++) begin
      v.cs = 0; v.pos = (i != 0); v.neg = 0; v.rw = 0;
      v.se = (i != 0) ? 1 : 0;
      v.nxt = (i == 8) ? 2 : 1;
      apply(v, 1000 + i);
    end
    v.cs = 0; v.pos = 0; v.neg = 0; v.rw = 0; v.se = 0; v.nxt = 5;
    apply(v, 1009);
    for (int i = 0; i < 3; i++) begin
      v.pos = 1; v.se = 1; v.nxt = 5;
      apply(v, 1010 + i);
    end
    @(negedge clk);
    sclk_posedge = 1'b1;
    #1;
    check("pre-reset sample_en", int'(sample_en), 1);
    #1;
    reset = 1'b1;
    #1;
    check("async reset state", int'(state), 0);
    got_outs = {27'd0, sample_en, addr_we, sr_we, miso_bufe, dm_we};
    check("async reset outputs", got_outs, 0);
    @(negedge clk);
    reset = 1'b0; sclk_posedge = 1'b0; cs_cond = 1'b0;
    @(posedge clk);
    #1;
    check("leave idle after reset", int'(state), 1);
    @(negedge clk);
    cs_cond = 1'b1;
    @(posedge clk);
    #1;
    check("final idle", int'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
